// File: rtl/toggle_pkg.sv
// Shared definitions for the pushbutton toggle pulse generator.
package toggle_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/toggle_pulse_gen.sv
// Debounces a raw pushbutton and emits one registered T/En pulse per accepted press.
//
//   state        | meaning
//   -------------+-----------------------------------------------
//   IDLE         | button released and debounced
//   PRESS_WAIT   | button seen high, counting stable-high samples
//   HELD         | press accepted, waiting for release (no repeat)
//   RELEASE_WAIT | button seen low, counting stable-low samples
module toggle_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = toggle_pkg::DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_in,
   output logic             t_out,
   output logic             en_out,
   output logic             busy,
   output logic [CNT_W-1:0] press_cnt
);

   import toggle_pkg::*;

   localparam int               DBC_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DBC_W-1:0] DBC_MAX = DBC_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DBC_W-1:0] DBC_ONE = DBC_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             btn_s;
   state_t           state, state_nxt;
   logic [DBC_W-1:0] dbc, dbc_nxt;
   logic             fire;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn_in),
      .q     (btn_s)
   );

   always_comb begin
      state_nxt = state;
      dbc_nxt   = dbc;
      fire      = 1'b0;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt = PRESS_WAIT;
               dbc_nxt   = DBC_ONE;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_nxt = IDLE;
               dbc_nxt   = '0;
            end else if (dbc == DBC_MAX) begin
               state_nxt = HELD;
               dbc_nxt   = '0;
               fire      = 1'b1;
            end else begin
               dbc_nxt = dbc + DBC_ONE;
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_nxt = RELEASE_WAIT;
               dbc_nxt   = DBC_ONE;
            end
         end
         RELEASE_WAIT: begin
            // a high sample here is release bounce, so the press is still in force
            if (btn_s) begin
               state_nxt = HELD;
               dbc_nxt   = '0;
            end else if (dbc == DBC_MAX) begin
               state_nxt = IDLE;
               dbc_nxt   = '0;
            end else begin
               dbc_nxt = dbc + DBC_ONE;
            end
         end
         default: begin
            state_nxt = IDLE;
            dbc_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dbc       <= '0;
         t_out     <= 1'b0;
         en_out    <= 1'b0;
         busy      <= 1'b0;
         press_cnt <= '0;
      end else begin
         state  <= state_nxt;
         dbc    <= dbc_nxt;
         t_out  <= fire;
         en_out <= fire;
         // decoded from the next state so busy lines up with the registered state
         busy   <= (state_nxt != IDLE);
         if (fire) press_cnt <= press_cnt + CNT_ONE;
      end
   end

endmodule
